servo_cmd_arbiter: RTL

SERVO_CMD_ARBITER -- requirements
Module: servo_cmd_arbiter

---
 rtl/servo_cmd_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/servo_cmd_arbiter.sv
// servo_cmd_arbiter
// Round-robin arbiter that picks one of NUM_REQ servo command requesters,
// forwards the winner's ratio to servo_ctrl as the new target, and keeps the
// previous target as the start ratio so the servo can ramp between them.
// After each grant the arbiter dwells for hold_cycles+1 HOLD cycles before it
// looks at requests again.
//
// Optional feature: define SERVO_ARB_CLAMP_EN to clamp the granted ratio into
// [min_ratio, max_ratio] (min_ratio wins when the bounds are inverted).
// Without the macro the ratio passes through untouched.
//
// Handshake: req[i] is a level held by requester i until it sees grant[i]
// pulse for one cycle; a request dropped before its grant is simply
// forgotten. Requests are not looked at while busy is high.
module servo_cmd_arbiter #(
  parameter int          NUM_REQ    = 4,
  parameter logic [7:0]  INIT_RATIO = 8'd20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_ratio,
  input  logic [7:0]             min_ratio,
  input  logic [7:0]             max_ratio,
  input  logic [15:0]            hold_cycles,
  input  logic                   stop,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   pwm_enable,
  output logic [7:0]             start_pwm_ratio,
  output logic [7:0]             target_pwm_ratio,
  output logic [1:0]             state_dbg
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [15:0]   cnt;

  logic          found;
  logic [PW-1:0] win;
  logic [PW-1:0] ptr_next;
  logic [7:0]    win_ratio;
  logic [7:0]    proc_ratio;

  assign state_dbg = state;

  // Round-robin search starting at ptr and wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  // Pointer moves one past the winner so the winner becomes lowest priority.
  always_comb begin
    ptr_next = (int'(win) == NUM_REQ - 1) ? '0 : win + PW'(1);
  end

  // Ratio of the winning requester, optionally clamped.
  always_comb begin
    win_ratio = req_ratio[8*int'(win) +: 8];
`ifdef SERVO_ARB_CLAMP_EN
    // Upper bound first, then lower bound: inverted bounds collapse to min.
    proc_ratio = (win_ratio > max_ratio) ? max_ratio : win_ratio;
    proc_ratio = (proc_ratio < min_ratio) ? min_ratio : proc_ratio;
`else
    proc_ratio = win_ratio;
`endif
  end

`ifndef SERVO_ARB_CLAMP_EN
  // Clamp bounds are intentionally unused in the pass-through build.
  logic unused_clamp_bounds;
  assign unused_clamp_bounds = ^{min_ratio, max_ratio};
`endif

  // Arbitration FSM with all outputs registered; stop aborts from any state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      cnt              <= '0;
      grant            <= '0;
      busy             <= 1'b0;
      pwm_enable       <= 1'b0;
      start_pwm_ratio  <= INIT_RATIO;
      target_pwm_ratio <= INIT_RATIO;
    end else if (stop) begin
      state      <= IDLE;
      grant      <= '0;
      busy       <= 1'b0;
      pwm_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state            <= GRANT;
            grant            <= NUM_REQ'(1) << win;
            start_pwm_ratio  <= target_pwm_ratio;
            target_pwm_ratio <= proc_ratio;
            pwm_enable       <= 1'b1;
            busy             <= 1'b1;
            ptr              <= ptr_next;
            cnt              <= hold_cycles;
          end
        end
        GRANT: begin
          grant <= '0;
          state <= HOLD;
        end
        HOLD: begin
          if (cnt == 16'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
